// File: rtl/chunk_comp_pkg.sv
// Shared encodings for the chunked magnitude comparator.
//   state_e       : controller states (IDLE/RUN)
//   RES_*         : packed {eq,gt,lt} result codes, one-hot once a result exists
//   RES_*_BIT     : bit positions of eq/gt/lt inside a packed result
package chunk_comp_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int RES_EQ_BIT = 2;
   localparam int RES_GT_BIT = 1;
   localparam int RES_LT_BIT = 0;

   localparam logic [2:0] RES_NONE = 3'b000;
   localparam logic [2:0] RES_EQ   = 3'b100;
   localparam logic [2:0] RES_GT   = 3'b010;
   localparam logic [2:0] RES_LT   = 3'b001;

endpackage

// File: rtl/slice_comp.sv
// Combinational unsigned magnitude compare of one CHUNK-bit slice.
// Ports:
//   a, b       : slice operands
//   eq, gt, lt : a==b, a>b, a<b (exactly one is high)
module slice_comp #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   output logic             eq,
   output logic             gt,
   output logic             lt
);

   assign eq = (a == b);
   assign gt = (a >  b);
   assign lt = (a <  b);

endmodule

// File: rtl/chunk_mag_comp.sv
// Multi-cycle magnitude comparator: compares two WIDTH-bit operands one
// CHUNK-bit slice per cycle, most significant slice first, and stops at the
// first slice that differs. Signed compares are done by flipping the sign bit
// of both operands at capture, which turns two's complement into offset
// binary so the unsigned slice compare gives the signed ordering.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start; last result held on eq/gt/lt
// ST_RUN  | comparing slice idx_q; busy=1; results frozen until done
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : request, accepted only while idle
//   a, b        : operands, captured with an accepted start
//   signed_mode : 1 = two's-complement compare, captured with start
//   busy        : comparison in progress
//   done        : one-cycle pulse when eq/gt/lt update
//   eq, gt, lt  : registered one-hot result
module chunk_mag_comp
   import chunk_comp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             gt,
   output logic             lt
);

   localparam int NCH   = WIDTH / CHUNK;
   localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

   generate
      if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
         $error("chunk_mag_comp: WIDTH must be a non-zero multiple of CHUNK");
      end
   endgenerate

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               done_q, done_d;
   logic [2:0]         res_q, res_d;

   logic [CHUNK-1:0]   a_sl;
   logic [CHUNK-1:0]   b_sl;
   logic               s_eq, s_gt, s_lt;

   // Slice select written as a constant-index mux so every leg is a fixed
   // part-select of the captured operands.
   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int i = 0; i < NCH; i++) begin
         if (idx_q == IDX_W'(i)) begin
            a_sl = a_q[i*CHUNK +: CHUNK];
            b_sl = b_q[i*CHUNK +: CHUNK];
         end
      end
   end

   slice_comp #(
      .CHUNK (CHUNK)
   ) u_slice_comp (
      .a  (a_sl),
      .b  (b_sl),
      .eq (s_eq),
      .gt (s_gt),
      .lt (s_lt)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      res_d   = res_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d              = a;
               b_d              = b;
               a_d[WIDTH-1]     = a[WIDTH-1] ^ signed_mode;
               b_d[WIDTH-1]     = b[WIDTH-1] ^ signed_mode;
               idx_d            = IDX_W'(NCH - 1);
               state_d          = ST_RUN;
            end
         end

         ST_RUN: begin
            if (!s_eq) begin
               res_d   = s_gt ? RES_GT : RES_LT;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (idx_q == '0) begin
               res_d   = RES_EQ;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               idx_d   = idx_q - 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         res_q   <= RES_NONE;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         res_q   <= res_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = done_q;
   assign eq   = res_q[RES_EQ_BIT];
   assign gt   = res_q[RES_GT_BIT];
   assign lt   = res_q[RES_LT_BIT];

endmodule

// File: tb/tb_chunk_mag_comp.sv
// Directed bench for chunk_mag_comp with WIDTH=16, CHUNK=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_chunk_mag_comp;

   localparam int WIDTH = 16;
   localparam int CHUNK = 4;

   // Expected {eq,gt,lt} patterns
   localparam logic [2:0] X_EQ = 3'b100;
   localparam logic [2:0] X_GT = 3'b010;
   localparam logic [2:0] X_LT = 3'b001;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             signed_mode;
   logic             busy;
   logic             done;
   logic             eq;
   logic             gt;
   logic             lt;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   chunk_mag_comp #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .a           (a),
      .b           (b),
      .signed_mode (signed_mode),
      .busy        (busy),
      .done        (done),
      .eq          (eq),
      .gt          (gt),
      .lt          (lt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One comparison from start to done. inj >= 0 pulses a conflicting start
   // for one cycle after edge inj of the running compare.
   task automatic run_cmp(input string tag, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic sm,
                          input int exp_lat, input logic [2:0] exp_res,
                          input int inj);
      logic [2:0] prev;
      int         lat;
      bit         got;
      @(negedge clk);
      chk({tag, ":idle_done"}, 32'(done), 32'd0);
      chk({tag, ":idle_busy"}, 32'(busy), 32'd0);
      prev        = {eq, gt, lt};
      a           = av;
      b           = bv;
      signed_mode = sm;
      start       = 1'b1;
      @(negedge clk);
      start       = 1'b0;
      a           = ~av;
      b           = bv;
      signed_mode = ~sm;
      chk({tag, ":busy0"}, 32'(busy), 32'd1);
      chk({tag, ":hold0"}, 32'({eq, gt, lt}), 32'(prev));
      lat = 0;
      got = 1'b0;
      while (!got && lat < 12) begin
         if (lat == inj) begin
            start = 1'b1;
            a     = 16'hFFFF;
            b     = 16'h0000;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat = lat + 1;
         if (done) got = 1'b1;
         else chk({tag, ":hold"}, 32'({eq, gt, lt}), 32'(prev));
      end
      start = 1'b0;
      chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, ":result"}, 32'({eq, gt, lt}), 32'(exp_res));
      chk({tag, ":busy_fall"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      a           = '0;
      b           = '0;
      signed_mode = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", 32'({busy, done, eq, gt, lt}), 32'd0);
      rst = 1'b0;

      run_cmp("u_1234_1235", 16'h1234, 16'h1235, 1'b0, 4, X_LT, -1);
      run_cmp("u_8000_0001", 16'h8000, 16'h0001, 1'b0, 1, X_GT, -1);
      run_cmp("s_8000_0001", 16'h8000, 16'h0001, 1'b1, 1, X_LT, -1);
      run_cmp("u_beef",      16'hBEEF, 16'hBEEF, 1'b0, 4, X_EQ, -1);
      run_cmp("u_1200_1210", 16'h1200, 16'h1210, 1'b0, 3, X_LT, -1);
      run_cmp("u_0005_0003", 16'h0005, 16'h0003, 1'b0, 4, X_GT, -1);
      run_cmp("s_fffe_ffff", 16'hFFFE, 16'hFFFF, 1'b1, 4, X_LT, -1);
      run_cmp("s_beef",      16'hBEEF, 16'hBEEF, 1'b1, 4, X_EQ, -1);

      // Back-to-back: new start asserted in the done cycle of s_beef.
      a           = 16'h0000;
      b           = 16'hFFFF;
      signed_mode = 1'b1;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("b2b:busy_no_gap", 32'(busy), 32'd1);
      chk("b2b:done_low",    32'(done), 32'd0);
      chk("b2b:hold_eq",     32'({eq, gt, lt}), 32'(X_EQ));
      @(negedge clk);
      chk("b2b:done",   32'(done), 32'd1);
      chk("b2b:result", 32'({eq, gt, lt}), 32'(X_GT));
      chk("b2b:busy",   32'(busy), 32'd0);

      // Conflicting start pulsed mid-compare must be ignored.
      run_cmp("ign_start", 16'h1234, 16'h1235, 1'b0, 4, X_LT, 1);
      @(negedge clk);
      chk("ign_start:no_reextend", 32'(busy), 32'd0);
      chk("ign_start:done_once",   32'(done), 32'd0);

      // Reset mid-compare with a simultaneous start: reset wins.
      a           = 16'h1234;
      b           = 16'h1234;
      signed_mode = 1'b0;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("rst_mid:busy0", 32'(busy), 32'd1);
      @(negedge clk);
      chk("rst_mid:no_done1", 32'(done), 32'd0);
      rst   = 1'b1;
      start = 1'b1;
      a     = 16'hFFFF;
      b     = 16'h0000;
      @(negedge clk);
      chk("rst_mid:cleared", 32'({busy, done, eq, gt, lt}), 32'd0);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("rst_mid:still_idle", 32'({busy, done, eq, gt, lt}), 32'd0);

      run_cmp("after_rst", 16'h00FF, 16'h0F00, 1'b0, 2, X_LT, -1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/chunk_mag_comp.md
CHUNK_MAG_COMP -- requirements
Module: chunk_mag_comp

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL provide parameter CHUNK, default 4, bits compared per cycle; WIDTH % CHUNK == 0 is mandatory; NCH = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port start  input  1  request; sampled only while busy=0.
REQ-006 SHALL have port a  input  WIDTH  operand A, sampled with accepted start.
REQ-007 SHALL have port b  input  WIDTH  operand B, sampled with accepted start.
REQ-008 SHALL have port signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with accepted start.
REQ-009 SHALL have port busy  output  1  comparison in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-011 SHALL have ports eq, gt, lt  output  1 each  A==B, A>B, A<B; registered.

Function
REQ-012 SHALL implement an FSM with states IDLE and RUN; reset state IDLE.
REQ-013 SHALL accept start on a rising edge when state=IDLE: capture a, b, signed_mode; load chunk index NCH-1; enter RUN; assert busy.
REQ-014 SHALL ignore start while busy=1; captured operands stay unchanged.
REQ-015 SHALL compare one CHUNK-bit slice per RUN cycle, MSB-first (index NCH-1 down to 0).
REQ-016 SHALL, in signed mode, invert bit WIDTH-1 of both captured operands before comparing (offset-binary), with no other difference from unsigned behaviour.
REQ-017 SHALL terminate early: on the first unequal slice, set gt or lt per that slice; clear the other two result bits; return to IDLE.
REQ-018 SHALL, if slice 0 is equal, set eq=1 and clear gt and lt; return to IDLE.
REQ-019 SHALL pulse done for exactly one cycle, aligned with the update of eq/gt/lt and with busy falling.
REQ-020 SHALL make latency = number of slices examined: done appears k cycles after the start edge, with 1 <= k <= NCH.
REQ-021 SHALL keep eq/gt/lt exactly one-hot after the first done; they hold until the next done.
REQ-022 SHALL accept a start asserted in the same cycle that done is high, because busy=0; the new comparison begins with no idle gap.
REQ-023 SHALL not change eq/gt/lt while busy=1.

Reset
REQ-024 SHALL drive busy=0, done=0, eq=0, gt=0, lt=0 and state IDLE on the rising edge with rst=1.
REQ-025 SHALL abort an in-progress comparison on reset mid-operation: no done pulse; the previous result is cleared.
REQ-026 SHALL give rst priority over start in the same cycle.

Structure
REQ-027 SHALL place the FSM state encoding (IDLE/RUN) and the result encoding constants in shared package chunk_comp_pkg.
REQ-028 SHALL use one sub-module, slice_comp: a combinational CHUNK-bit magnitude compare with outputs eq/gt/lt; it is instantiated once and fed from a muxed slice of the captured operands.
REQ-029 SHALL flag WIDTH % CHUNK != 0 at elaboration (static assertion).

Verification (WIDTH=16, CHUNK=4)
REQ-030 SHALL check unsigned a=0x1234, b=0x1235 -> done 4 cycles after start, lt=1, eq=gt=0.
REQ-031 SHALL check a=0x8000, b=0x0001 -> unsigned gives gt=1 and signed gives lt=1, each with done 1 cycle after start (early termination).
REQ-032 SHALL check a=b=0xBEEF, signed and unsigned -> done after 4 cycles, eq=1; then re-start with a=0x0000, b=0xFFFF (signed) asserted on the done cycle -> gt=1 after 1 cycle.
REQ-033 SHALL check that start pulsed at cycle 2 of a running compare with different operands is ignored -> the original result is reported and busy is never re-extended.
REQ-034 SHALL check rst=1 at cycle 2 of a 4-cycle compare -> no done pulse; busy=eq=gt=lt=0 the next cycle; a fresh start then completes normally.
